// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter width; a single-digit operation still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
      int unsigned n;
      n = (digit == 0) ? 1 : width / digit;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit gate-level full adder; DIGIT of these form the per-cycle ripple chain.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | ((x ^ y) & z);

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock
// through a fa_cell ripple chain, with the carry held in a register between digits.
module serial_add_sub
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);

   generate
      if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_err
         $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGIT");
      end
   endgenerate

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last_digit;
   logic [DIGIT-1:0] dsum;
   logic [DIGIT:0]   chain_c;

   // Per-cycle ripple chain over the low DIGIT bits of the operand shifters.
   assign chain_c[0] = carry;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_fa
         fa_cell u_fa (
            .x (a_sh[i]),
            .y (b_sh[i]),
            .z (chain_c[i]),
            .s (dsum[i]),
            .c (chain_c[i+1])
         );
      end
   endgenerate

   assign last_digit = (cnt == CW'(NDIG - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Handshake outputs are decoded from state only, so no in_valid/out_ready feed-through.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (last_digit) state_next = DONE;
         end
         DONE: begin
            out_valid = !rst;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Subtraction is a + ~b + ~cin, so inversion happens once at accept time.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= cin ^ sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= chain_c[DIGIT];
               cnt   <= cnt + CW'(1);
               sum   <= (sum >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
               if (last_digit) begin
                  cout <= chain_c[DIGIT];
                  ovf  <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
